// File: rtl/dmb_pkg.sv
// Shared DMB definitions: byte width, default word width and the reader FSM state type.
package dmb_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned DMB_WORD_W = 32;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } rd_state_e;

endpackage

// File: rtl/dmb_fifo_reader.sv
// Pops words from a show-ahead FIFO and streams them out one byte per cycle, LSB first,
// with a valid/ready handshake and a saturating count of words popped.
module dmb_fifo_reader
    import dmb_pkg::*;
#(
    parameter int unsigned FIFO_DATA_WIDTH = DMB_WORD_W,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       flush_i,
    output logic                       rdReq,
    input  logic                       rdAck,
    input  logic [FIFO_DATA_WIDTH-1:0] rdata,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic [BYTE_W-1:0]          byte_data_o,
    output logic                       byte_last_o,
    output logic [CNT_WIDTH-1:0]       words_rd_o
);

    localparam int unsigned NBYTES = FIFO_DATA_WIDTH / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    rd_state_e                state_q, state_d;
    logic [FIFO_DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     accept;
    logic                     pop;

    assign byte_valid_o = (state_q == ST_SEND);
    assign byte_data_o  = shift_q[BYTE_W-1:0];
    assign byte_last_o  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    assign words_rd_o   = cnt_q;
    assign accept       = byte_valid_o & byte_ready_i;

    // Refill is allowed when empty or as the final byte leaves, so words chain without a bubble.
    assign rdReq = ~rst_i & en_i & ~flush_i &
                   ((state_q == ST_IDLE) | (accept & byte_last_o));
    assign pop   = rdReq & rdAck;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (pop && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Flush wins over any handshake and drops the held word.
        if (flush_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else if (pop) begin
            state_d = ST_SEND;
            shift_d = rdata;
            idx_d   = '0;
        end else if (accept) begin
            if (byte_last_o) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else begin
                shift_d = shift_q >> BYTE_W;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmb_fifo_reader.sv
// Scoreboard bench for dmb_fifo_reader with a behavioural show-ahead FIFO on the read side.
module tb_dmb_fifo_reader;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          en_i;
    logic          flush_i;
    logic          rdReq;
    logic          rdAck;
    logic [W-1:0]  rdata;
    logic          byte_valid_o;
    logic          byte_ready_i;
    logic [7:0]    byte_data_o;
    logic          byte_last_o;
    logic [CW-1:0] words_rd_o;

    dmb_fifo_reader #(.FIFO_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .flush_i      (flush_i),
        .rdReq        (rdReq),
        .rdAck        (rdAck),
        .rdata        (rdata),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_data_o  (byte_data_o),
        .byte_last_o  (byte_last_o),
        .words_rd_o   (words_rd_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural FIFO: head word always visible, rdAck while non-empty and enabled.
    logic [W-1:0] fifo_mem [0:63];
    logic [5:0]   wr_ptr = '0;
    logic [5:0]   rd_ptr = '0;
    logic         fifo_on;
    int           cyc = 0;
    int           pop_q[$];

    assign rdAck = fifo_on && (wr_ptr != rd_ptr);
    assign rdata = fifo_mem[rd_ptr];

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i) begin
        if (rdReq && rdAck) begin
            rd_ptr <= rd_ptr + 6'd1;
            pop_q.push_back(cyc);
        end
    end

    logic [8:0] exp_q[$];
    int         acc_q[$];
    int         checks    = 0;
    int         failures  = 0;
    int         exp_words = 0;

    task automatic push_word(input logic [W-1:0] w, input int nexp);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 6'd1;
        for (int i = 0; i < nexp; i++) begin
            exp_q.push_back({(i == 3), w[8*i +: 8]});
        end
    endtask

    task automatic run_monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && byte_valid_o && byte_ready_i && !flush_i) begin
                checks++;
                acc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got byte=%02h last=%0b, required no byte", byte_data_o, byte_last_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({byte_last_o, byte_data_o} !== e) begin
                        failures++;
                        $display("FAIL sb_byte: got byte=%02h last=%0b, required byte=%02h last=%0b",
                                 byte_data_o, byte_last_o, e[7:0], e[8]);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && wr_ptr == rd_ptr && !byte_valid_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL %s_drain_timeout: got %0d bytes still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk_i);
        while (!byte_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!byte_valid_o) begin
            failures++;
            $display("FAIL %s_valid_timeout: got byte_valid_o=0, required 1", name);
        end
    endtask

    task automatic check_count(input string name);
        logic [CW-1:0] e;
        e = (exp_words > 15) ? 4'd15 : 4'(exp_words);
        checks++;
        if (words_rd_o !== e) begin
            failures++;
            $display("FAIL %s_count: got words_rd_o=%0d, required %0d", name, words_rd_o, e);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b1; flush_i = 1'b0; byte_ready_i = 1'b1; fifo_on = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({rdReq, byte_valid_o, byte_data_o, byte_last_o, words_rd_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdReq=%0b valid=%0b data=%02h last=%0b cnt=%0d, required all 0",
                     rdReq, byte_valid_o, byte_data_o, byte_last_o, words_rd_o);
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
    endtask

    task automatic test_single();
        int pb;
        pb = pop_q.size();
        acc_q.delete();
        @(posedge clk_i); #1 push_word(32'h44332211, 4);
        drain("single");
        exp_words += 1;
        check_count("single");
        checks++;
        if (acc_q.size() != 4 || pop_q.size() != pb + 1 ||
            acc_q[3] - acc_q[0] != 3 || acc_q[0] != pop_q[pb] + 1) begin
            failures++;
            $display("FAIL single_timing: got %0d bytes/%0d pops, required 4 consecutive bytes one cycle after 1 pop",
                     acc_q.size(), pop_q.size() - pb);
        end
    endtask

    task automatic test_back_to_back();
        int pb;
        pb = pop_q.size();
        acc_q.delete();
        @(posedge clk_i); #1;
        push_word(32'hA3A2A1A0, 4);
        push_word(32'hB3B2B1B0, 4);
        drain("b2b");
        exp_words += 2;
        check_count("b2b");
        checks++;
        if (acc_q.size() != 8 || pop_q.size() != pb + 2 || acc_q[7] - acc_q[0] != 7) begin
            failures++;
            $display("FAIL b2b_gapless: got %0d bytes over %0d cycles, required 8 over 8", acc_q.size(),
                     (acc_q.size() == 8) ? acc_q[7] - acc_q[0] + 1 : 0);
        end else begin
            checks++;
            if (pop_q[pb + 1] != acc_q[3]) begin
                failures++;
                $display("FAIL b2b_pop_on_last: got second pop at cycle %0d, required %0d", pop_q[pb + 1], acc_q[3]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk_i); #1 push_word(32'hDDCCBBAA, 4);
        wait_valid("bp");
        @(posedge clk_i); #1 byte_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (!byte_valid_o || byte_data_o !== 8'hBB || byte_last_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: got valid=%0b data=%02h last=%0b, required 1 bb 0",
                         byte_valid_o, byte_data_o, byte_last_o);
            end
        end
        @(posedge clk_i); #1 byte_ready_i = 1'b1;
        drain("bp");
        exp_words += 1;
        check_count("bp");
    endtask

    task automatic test_flush();
        @(posedge clk_i); #1;
        push_word(32'h13121110, 2);
        push_word(32'h23222120, 4);
        wait_valid("flush");
        @(posedge clk_i);
        @(posedge clk_i); #1 flush_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (!byte_valid_o || byte_data_o !== 8'h12 || rdReq !== 1'b0) begin
            failures++;
            $display("FAIL flush_cycle: got valid=%0b data=%02h rdReq=%0b, required 1 12 0",
                     byte_valid_o, byte_data_o, rdReq);
        end
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (byte_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: got byte_valid_o=%0b, required 0", byte_valid_o);
        end
        drain("flush");
        exp_words += 2;
        check_count("flush");
    endtask

    task automatic test_enable_empty();
        @(posedge clk_i); #1;
        en_i = 1'b0;
        push_word(32'h87868584, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (rdReq !== 1'b0 || byte_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL en_gate: got rdReq=%0b valid=%0b, required 0 0", rdReq, byte_valid_o);
            end
        end
        @(posedge clk_i); #1 en_i = 1'b1;
        wait_valid("en");
        @(posedge clk_i); #1 en_i = 1'b0;
        drain("en_inflight");
        @(posedge clk_i); #1;
        en_i = 1'b1;
        fifo_on = 1'b0;
        push_word(32'h97969594, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (byte_valid_o !== 1'b0 || rdReq !== 1'b1) begin
                failures++;
                $display("FAIL empty_idle: got valid=%0b rdReq=%0b, required 0 1", byte_valid_o, rdReq);
            end
        end
        @(posedge clk_i); #1 fifo_on = 1'b1;
        drain("empty");
        exp_words += 2;
        check_count("en_empty");
    endtask

    task automatic test_saturation();
        @(posedge clk_i); #1;
        for (int i = 0; i < 20; i++) begin
            push_word(32'h01010101 * (i + 1) ^ 32'h00FF00FF, 4);
        end
        drain("sat");
        exp_words += 20;
        check_count("sat");
    endtask

    task automatic test_reset_mid();
        int pb;
        int rel;
        @(posedge clk_i); #1 push_word(32'h77665544, 4);
        wait_valid("rst_mid");
        @(posedge clk_i); #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({rdReq, byte_valid_o, byte_data_o, byte_last_o, words_rd_o} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got rdReq=%0b valid=%0b data=%02h last=%0b cnt=%0d, required all 0",
                     rdReq, byte_valid_o, byte_data_o, byte_last_o, words_rd_o);
        end
        exp_q.delete();
        exp_words = 0;
        pb = pop_q.size();
        push_word(32'h0D0C0B0A, 4);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (rdReq !== 1'b0 || byte_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_hold: got rdReq=%0b valid=%0b, required 0 0", rdReq, byte_valid_o);
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
        rel = cyc;
        drain("rst_release");
        exp_words = 1;
        check_count("rst_release");
        checks++;
        if (pop_q.size() != pb + 1 || pop_q[pb] != rel) begin
            failures++;
            $display("FAIL rst_first_pop: got %0d pops first at %0d, required 1 pop at cycle %0d",
                     pop_q.size() - pb, (pop_q.size() > pb) ? pop_q[pb] : -1, rel);
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_enable_empty();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
